// File: rtl/iguana_pkg.sv
// Purpose: shared types and default timing constants for the iguana GPIO/USB pad mux.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iguana_pkg;

  // Pad-ownership FSM encoding; the value is exported directly on state_o.
  typedef enum logic [1:0] {
    IOMUX_GPIO    = 2'd0,
    IOMUX_GUARD_U = 2'd1,
    IOMUX_USB     = 2'd2,
    IOMUX_GUARD_G = 2'd3
  } iomux_state_e;

  localparam int unsigned IomuxDebounceCycles = 1024;
  localparam int unsigned IomuxGuardCycles    = 16;

endpackage

// File: rtl/iguana_iomux_ctrl_if.sv
// Purpose: line/drive bundle between the pad mux and the USB controller ports.
// Latency: n/a (wires only).
// Backpressure: none; plain level signals.
interface iguana_iomux_ctrl_if #(
  parameter int unsigned NumPorts = 2
);

  logic [NumPorts-1:0] usb_dm_o;     // line value seen by the controller
  logic [NumPorts-1:0] usb_dp_o;
  logic [NumPorts-1:0] usb_dm_i;     // controller drive value
  logic [NumPorts-1:0] usb_dp_i;
  logic [NumPorts-1:0] usb_dm_oe_i;  // controller output enable
  logic [NumPorts-1:0] usb_dp_oe_i;

  // USB controller side
  modport master (
    input  usb_dm_o, usb_dp_o,
    output usb_dm_i, usb_dp_i, usb_dm_oe_i, usb_dp_oe_i
  );

  // Pad mux side
  modport slave (
    output usb_dm_o, usb_dp_o,
    input  usb_dm_i, usb_dp_i, usb_dm_oe_i, usb_dp_oe_i
  );

endinterface

// File: rtl/iguana_iomux_debounce.sv
// Purpose: synchronise the asynchronous USB-select pin and accept a change only after it holds steady.
// Latency: stable_o follows a clean pin edge SyncStages+DebounceCycles cycles later.
// Backpressure: none.
module iguana_iomux_debounce
  import iguana_pkg::*;
#(
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = IomuxDebounceCycles
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pin_i,
  output logic stable_o
);

  localparam int unsigned    CntW    = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  logic [SyncStages-1:0] sync_q, sync_d;
  logic                  synced;
  logic                  stable_q, stable_d;
  logic [CntW-1:0]       cnt_q, cnt_d;

  assign synced   = sync_q[SyncStages-1];
  assign stable_o = stable_q;

  // Shift the raw pin through the synchroniser chain.
  always_comb begin
    sync_d = {sync_q[SyncStages-2:0], pin_i};
  end

  // Count consecutive cycles the synced pin disagrees with the accepted value; any agreement restarts.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (synced == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = synced;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Register synchroniser, accepted value and counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/iguana_iomux_ctrl.sv
// Purpose: hand shared pads between SoC GPIO and USB ports via a tri-stated guard phase.
// Latency: override request acts next cycle; pin request after sync+debounce; handover takes GuardCycles.
// Backpressure: none; the mux datapath is combinational from the registered owner state.
module iguana_iomux_ctrl
  import iguana_pkg::*;
#(
  parameter int unsigned GpioWidth      = 32,
  parameter int unsigned NumPorts       = 2,
  parameter int unsigned PortPinBase    = 1,
  parameter int unsigned SelPin         = 0,
  parameter int unsigned SyncStages     = 2,
  parameter int unsigned DebounceCycles = IomuxDebounceCycles,
  parameter int unsigned GuardCycles    = IomuxGuardCycles
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sw_ovr_en_i,
  input  logic                 sw_usb_sel_i,
  input  logic [GpioWidth-1:0] pad_gpio_i,
  output logic [GpioWidth-1:0] pad_gpio_o,
  output logic [GpioWidth-1:0] pad_gpio_en_o,
  output logic [GpioWidth-1:0] soc_gpio_o,
  input  logic [GpioWidth-1:0] soc_gpio_i,
  input  logic [GpioWidth-1:0] soc_gpio_en_i,
  iguana_iomux_ctrl_if.slave   usb,
  output logic                 usb_active_o,
  output logic [1:0]           state_o
);

  localparam int unsigned     ShW      = 2 * NumPorts;
  localparam int unsigned     GcntW    = $clog2(GuardCycles + 1);
  localparam logic [GcntW-1:0] GcntLast = GcntW'(GuardCycles - 1);

  localparam logic [1:0] ST_GPIO    = IOMUX_GPIO;
  localparam logic [1:0] ST_GUARD_U = IOMUX_GUARD_U;
  localparam logic [1:0] ST_USB     = IOMUX_USB;
  localparam logic [1:0] ST_GUARD_G = IOMUX_GUARD_G;

  // Parameter sanity: shared block must fit and must not swallow the select pin.
  if (PortPinBase + ShW > GpioWidth) begin : g_err_range
    $error("iguana_iomux_ctrl: shared pads exceed GpioWidth");
  end
  if (SelPin >= PortPinBase && SelPin < PortPinBase + ShW) begin : g_err_selpin
    $error("iguana_iomux_ctrl: SelPin lies inside the shared pad range");
  end
  if (DebounceCycles < 1) begin : g_err_debounce
    $error("iguana_iomux_ctrl: DebounceCycles must be >= 1");
  end
  if (GuardCycles < 1) begin : g_err_guard
    $error("iguana_iomux_ctrl: GuardCycles must be >= 1");
  end
  if (SyncStages < 2) begin : g_err_sync
    $error("iguana_iomux_ctrl: SyncStages must be >= 2");
  end

  logic             stable;
  logic             req;
  logic [1:0]       state_q, state_d;
  logic [GcntW-1:0] gcnt_q, gcnt_d;
  logic             usb_active_q, usb_active_d;

  // Shared pads packed as {.., dp1, dm1, dp0, dm0}, matching pad order from PortPinBase upwards.
  logic [ShW-1:0]      usb_pad_dat, usb_pad_en, pad_shared;
  logic [NumPorts-1:0] line_dm, line_dp;

  iguana_iomux_debounce #(
    .SyncStages     (SyncStages),
    .DebounceCycles (DebounceCycles)
  ) u_debounce (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .pin_i    (pad_gpio_i[SelPin]),
    .stable_o (stable)
  );

  assign req        = sw_ovr_en_i ? sw_usb_sel_i : stable;
  assign pad_shared = pad_gpio_i[PortPinBase +: ShW];

  for (genvar p = 0; p < NumPorts; p++) begin : g_port
    assign usb_pad_dat[2*p]   = usb.usb_dm_i[p];
    assign usb_pad_dat[2*p+1] = usb.usb_dp_i[p];
    assign usb_pad_en[2*p]    = usb.usb_dm_oe_i[p];
    assign usb_pad_en[2*p+1]  = usb.usb_dp_oe_i[p];
    assign line_dm[p]         = pad_shared[2*p];
    assign line_dp[p]         = pad_shared[2*p+1];
  end

  // Ownership FSM: every GPIO<->USB move passes through a full tri-state guard; only GUARD_U may abort.
  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    case (state_q)
      ST_GPIO: begin
        if (req) begin
          state_d = ST_GUARD_U;
          gcnt_d  = '0;
        end
      end
      ST_GUARD_U: begin
        if (!req) begin
          state_d = ST_GPIO;
        end else if (gcnt_q == GcntLast) begin
          state_d = ST_USB;
        end else begin
          gcnt_d = gcnt_q + GcntW'(1);
        end
      end
      ST_USB: begin
        if (!req) begin
          state_d = ST_GUARD_G;
          gcnt_d  = '0;
        end
      end
      ST_GUARD_G: begin
        if (gcnt_q == GcntLast) begin
          state_d = ST_GPIO;
        end else begin
          gcnt_d = gcnt_q + GcntW'(1);
        end
      end
    endcase
    usb_active_d = (state_d == ST_USB);
  end

  // State, guard counter and the registered USB-active flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_GPIO;
      gcnt_q       <= '0;
      usb_active_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      gcnt_q       <= gcnt_d;
      usb_active_q <= usb_active_d;
    end
  end

  assign state_o      = state_q;
  assign usb_active_o = usb_active_q;

  // Pad mux: SoC owns everything by default; shared block is overridden by USB or tri-stated in guards.
  always_comb begin
    pad_gpio_o    = soc_gpio_i;
    pad_gpio_en_o = soc_gpio_en_i;
    soc_gpio_o    = pad_gpio_i;
    usb.usb_dm_o  = '0;
    usb.usb_dp_o  = '1;
    case (state_q)
      ST_USB: begin
        pad_gpio_o[PortPinBase +: ShW]    = usb_pad_dat;
        pad_gpio_en_o[PortPinBase +: ShW] = usb_pad_en;
        soc_gpio_o[PortPinBase +: ShW]    = '0;
        usb.usb_dm_o                      = line_dm;
        usb.usb_dp_o                      = line_dp;
      end
      ST_GUARD_U, ST_GUARD_G: begin
        pad_gpio_o[PortPinBase +: ShW]    = '0;
        pad_gpio_en_o[PortPinBase +: ShW] = '0;
        soc_gpio_o[PortPinBase +: ShW]    = '0;
      end
      default: begin
      end
    endcase
    pad_gpio_en_o[SelPin] = 1'b0;
  end

endmodule

// File: tb/tb_iguana_iomux_ctrl.sv
// Purpose: self-checking bench for iguana_iomux_ctrl with short debounce/guard timing.
// Latency: expected states queued per driven cycle and compared one edge later.
// Backpressure: n/a.
module tb_iguana_iomux_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        sw_ovr_en_i;
  logic        sw_usb_sel_i;
  logic [31:0] pad_rand;
  logic        sel_pin;
  logic [31:0] pad_gpio_i;
  logic [31:0] pad_gpio_o;
  logic [31:0] pad_gpio_en_o;
  logic [31:0] soc_gpio_o;
  logic [31:0] soc_gpio_i;
  logic [31:0] soc_gpio_en_i;
  logic        usb_active_o;
  logic [1:0]  state_o;

  int checks = 0;
  int errors = 0;

  logic [1:0] exp_q[$];

  iguana_iomux_ctrl_if #(.NumPorts(2)) usb_if ();

  assign pad_gpio_i = {pad_rand[31:1], sel_pin};

  iguana_iomux_ctrl #(
    .GpioWidth      (32),
    .NumPorts       (2),
    .PortPinBase    (1),
    .SelPin         (0),
    .SyncStages     (2),
    .DebounceCycles (4),
    .GuardCycles    (3)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .sw_ovr_en_i   (sw_ovr_en_i),
    .sw_usb_sel_i  (sw_usb_sel_i),
    .pad_gpio_i    (pad_gpio_i),
    .pad_gpio_o    (pad_gpio_o),
    .pad_gpio_en_o (pad_gpio_en_o),
    .soc_gpio_o    (soc_gpio_o),
    .soc_gpio_i    (soc_gpio_i),
    .soc_gpio_en_i (soc_gpio_en_i),
    .usb           (usb_if),
    .usb_active_o  (usb_active_o),
    .state_o       (state_o)
  );

  always #5 clk_i = ~clk_i;

  // Fresh random values on every data input that does not steer the FSM.
  task automatic rand_io();
    pad_rand            = $urandom;
    soc_gpio_i          = $urandom;
    soc_gpio_en_i       = $urandom;
    usb_if.usb_dm_i     = 2'($urandom);
    usb_if.usb_dp_i     = 2'($urandom);
    usb_if.usb_dm_oe_i  = 2'($urandom);
    usb_if.usb_dp_oe_i  = 2'($urandom);
  endtask

  // Reference pad/line picture for a given owner state, built from the bench's own inputs.
  // Packing: {pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_dm_o, usb_dp_o}.
  function automatic logic [99:0] exp_io(input logic [1:0] st);
    logic [31:0] po, pe, so;
    logic [1:0]  dm, dp;
    po = soc_gpio_i;
    pe = soc_gpio_en_i;
    so = pad_gpio_i;
    dm = 2'b00;
    dp = 2'b11;
    if (st == 2'd2) begin
      po[4:1] = {usb_if.usb_dp_i[1], usb_if.usb_dm_i[1], usb_if.usb_dp_i[0], usb_if.usb_dm_i[0]};
      pe[4:1] = {usb_if.usb_dp_oe_i[1], usb_if.usb_dm_oe_i[1],
                 usb_if.usb_dp_oe_i[0], usb_if.usb_dm_oe_i[0]};
      so[4:1] = 4'b0000;
      dm      = {pad_gpio_i[3], pad_gpio_i[1]};
      dp      = {pad_gpio_i[4], pad_gpio_i[2]};
    end else if (st != 2'd0) begin
      po[4:1] = 4'b0000;
      pe[4:1] = 4'b0000;
      so[4:1] = 4'b0000;
    end
    pe[0] = 1'b0;
    return {po, pe, so, dm, dp};
  endfunction

  task automatic test_reset();
    logic [99:0] io;
    rst_i        = 1'b1;
    sw_ovr_en_i  = 1'b0;
    sw_usb_sel_i = 1'b0;
    sel_pin      = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_io();
      @(negedge clk_i);
    end
    checks++;
    if (state_o !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got %0d want 0", state_o);
    end
    checks++;
    if (usb_active_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_active: got %b want 0", usb_active_o);
    end
    checks++;
    if (pad_gpio_en_o[0] !== 1'b0) begin
      errors++;
      $display("FAIL reset_selpin_en: got %b want 0", pad_gpio_en_o[0]);
    end
    checks++;
    if (pad_gpio_o[4:1] !== soc_gpio_i[4:1]) begin
      errors++;
      $display("FAIL reset_shared_pads: got %h want %h", pad_gpio_o[4:1], soc_gpio_i[4:1]);
    end
    checks++;
    if (usb_if.usb_dp_o !== 2'b11 || usb_if.usb_dm_o !== 2'b00) begin
      errors++;
      $display("FAIL reset_idle_j: got dm=%b dp=%b want dm=00 dp=11", usb_if.usb_dm_o, usb_if.usb_dp_o);
    end
    io = exp_io(2'd0);
    checks++;
    if ({pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o} !== io) begin
      errors++;
      $display("FAIL reset_io: got %h want %h",
               {pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o}, io);
    end
    rst_i = 1'b0;
  endtask

  // Pin up: 6 cycles to accept, 3 guard cycles, USB; pin down: 6 cycles, 3 guard cycles, GPIO.
  task automatic test_pin_select();
    logic [1:0]  e;
    logic [99:0] io;
    repeat (6) exp_q.push_back(2'd0);
    repeat (3) exp_q.push_back(2'd1);
    repeat (9) exp_q.push_back(2'd2);
    repeat (3) exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    for (int i = 0; i < 22; i++) begin
      rand_io();
      sel_pin = (i < 12);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if (state_o !== e) begin
        errors++;
        $display("FAIL pin_select_state cyc %0d: got %0d want %0d", i, state_o, e);
      end
      checks++;
      if (usb_active_o !== (e == 2'd2)) begin
        errors++;
        $display("FAIL pin_select_active cyc %0d: got %b want %b", i, usb_active_o, (e == 2'd2));
      end
      io = exp_io(e);
      checks++;
      if ({pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o} !== io) begin
        errors++;
        $display("FAIL pin_select_io cyc %0d: got %h want %h", i,
                 {pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o}, io);
      end
    end
  endtask

  // Three-cycle pin pulse is shorter than sync+debounce: ownership never moves.
  task automatic test_glitch();
    logic [1:0]  e;
    logic [99:0] io;
    for (int i = 0; i < 14; i++) begin
      rand_io();
      sel_pin = (i < 3);
      exp_q.push_back(2'd0);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if (state_o !== e || usb_active_o !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc %0d: got state=%0d active=%b want state=%0d active=0",
                 i, state_o, usb_active_o, e);
      end
      io = exp_io(e);
      checks++;
      if ({pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o} !== io) begin
        errors++;
        $display("FAIL glitch_io cyc %0d: got %h want %h", i,
                 {pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o}, io);
      end
    end
  endtask

  // One-cycle software request: GUARD_U for one cycle, then straight back to GPIO.
  task automatic test_abort();
    logic [1:0]  e;
    logic [99:0] io;
    sw_ovr_en_i = 1'b1;
    exp_q.push_back(2'd1);
    repeat (5) exp_q.push_back(2'd0);
    for (int i = 0; i < 6; i++) begin
      rand_io();
      sw_usb_sel_i = (i == 0);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if (state_o !== e) begin
        errors++;
        $display("FAIL abort_state cyc %0d: got %0d want %0d", i, state_o, e);
      end
      checks++;
      if (usb_active_o !== 1'b0) begin
        errors++;
        $display("FAIL abort_active cyc %0d: got %b want 0", i, usb_active_o);
      end
      io = exp_io(e);
      checks++;
      if ({pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o} !== io) begin
        errors++;
        $display("FAIL abort_io cyc %0d: got %h want %h", i,
                 {pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o}, io);
      end
    end
  endtask

  // Enter USB, drop request for one cycle, re-request during GUARD_G: guard still runs 3 cycles.
  task automatic test_exit();
    logic [1:0]  e;
    logic [99:0] io;
    logic [1:0]  tbl [13];
    tbl = '{2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    sw_ovr_en_i = 1'b1;
    for (int i = 0; i < 13; i++) begin
      rand_io();
      sw_usb_sel_i = (i != 5);
      exp_q.push_back(tbl[i]);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if (state_o !== e) begin
        errors++;
        $display("FAIL exit_state cyc %0d: got %0d want %0d", i, state_o, e);
      end
      checks++;
      if (usb_active_o !== (e == 2'd2)) begin
        errors++;
        $display("FAIL exit_active cyc %0d: got %b want %b", i, usb_active_o, (e == 2'd2));
      end
      io = exp_io(e);
      checks++;
      if ({pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o} !== io) begin
        errors++;
        $display("FAIL exit_io cyc %0d: got %h want %h", i,
                 {pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o}, io);
      end
    end
  endtask

  // One-cycle reset while in USB: GPIO immediately, no guard; still-asserted request then re-enters.
  task automatic test_reset_in_usb();
    logic [1:0]  e;
    logic [99:0] io;
    logic [1:0]  tbl [5];
    tbl = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2};
    sw_ovr_en_i  = 1'b1;
    sw_usb_sel_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rand_io();
      rst_i = (i == 0);
      exp_q.push_back(tbl[i]);
      @(negedge clk_i);
      e = exp_q.pop_front();
      checks++;
      if (state_o !== e) begin
        errors++;
        $display("FAIL rst_usb_state cyc %0d: got %0d want %0d", i, state_o, e);
      end
      checks++;
      if (usb_active_o !== (e == 2'd2)) begin
        errors++;
        $display("FAIL rst_usb_active cyc %0d: got %b want %b", i, usb_active_o, (e == 2'd2));
      end
      io = exp_io(e);
      checks++;
      if ({pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o} !== io) begin
        errors++;
        $display("FAIL rst_usb_io cyc %0d: got %h want %h", i,
                 {pad_gpio_o, pad_gpio_en_o, soc_gpio_o, usb_if.usb_dm_o, usb_if.usb_dp_o}, io);
      end
    end
    rst_i = 1'b0;
  endtask

  initial begin
    rst_i        = 1'b1;
    sw_ovr_en_i  = 1'b0;
    sw_usb_sel_i = 1'b0;
    sel_pin      = 1'b0;
    rand_io();
    test_reset();
    test_pin_select();
    test_glitch();
    test_abort();
    test_exit();
    test_reset_in_usb();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
